// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one partial-product step per clock.
// Optional macro MULT_SEQ_EARLY_EXIT_EN ends the run as soon as no multiplier bits remain.
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_msh;
  logic [WIDTH-1:0]     r_qsh;
  logic [CW-1:0]        r_cnt;

  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     w_qsh_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_last;

  assign w_acc_nxt = r_acc + (r_qsh[0] ? r_msh : '0);
  assign w_qsh_nxt = r_qsh >> 1;
  assign w_cnt_nxt = r_cnt - 1'b1;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Once the multiplier has shifted out all ones, further steps add nothing.
  assign w_last = (w_cnt_nxt == '0) || (w_qsh_nxt == '0);
`else
  assign w_last = (w_cnt_nxt == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      r_acc   <= '0;
      r_msh   <= '0;
      r_qsh   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
            r_acc   <= '0;
            r_msh   <= {{WIDTH{1'b0}}, m};
            r_qsh   <= q;
            r_cnt   <= CW'(WIDTH);
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_msh <= r_msh << 1;
          r_qsh <= w_qsh_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_last) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= w_acc_nxt;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl at WIDTH=4; expected latencies follow MULT_SEQ_EARLY_EXIT_EN.
module tb_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] m = '0;
  logic [3:0] q = '0;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_pass = 0;
  int n_total = 0;

  mult_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .q(q),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v) $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    else n_pass++;
  endtask

  // Launches one op and waits for done; start is dropped after edge 0.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] ep, input int elat, input string nm);
    int n;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1; m = a; q = b;
    @(posedge clk); #1;
    start = 1'b0; m = '0; q = '0;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, n, elat);
    chk({nm, " busy during run"}, {31'd0, busy_ok}, 1);
    chk({nm, " product"}, {24'd0, product}, {24'd0, ep});
    chk({nm, " busy at done"}, {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk({nm, " done one cycle"}, {31'd0, done}, 0);
    chk({nm, " product held"}, {24'd0, product}, {24'd0, ep});
  endtask

  task automatic test_reset();
    #2;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset product", {24'd0, product}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle holds busy", {31'd0, busy}, 0);
    chk("idle holds done", {31'd0, done}, 0);
  endtask

  task automatic test_basic();
    run_op(4'd13, 4'd11, 8'd143, 4, "13x11");
    run_op(4'd15, 4'd15, 8'd225, 4, "15x15");
    run_op(4'd0,  4'd9,  8'd0,   4, "0x9");
    run_op(4'd3,  4'd1,  8'd3,   EE ? 1 : 4, "3x1");
    run_op(4'd5,  4'd0,  8'd0,   EE ? 1 : 4, "5x0");
    run_op(4'd1,  4'd15, 8'd15,  4, "1x15");
  endtask

  task automatic test_ignore_start();
    int pulses;
    int first_at;
    @(negedge clk);
    start = 1'b1; m = 4'd13; q = 4'd11;
    @(posedge clk); #1;          // edge 0
    start = 1'b0; m = '0; q = '0;
    @(posedge clk); #1;          // edge 1
    start = 1'b1; m = 4'd1; q = 4'd1;
    @(posedge clk); #1;          // edge 2: start must be ignored
    start = 1'b0; m = '0; q = '0;
    pulses = 0;
    first_at = -1;
    for (int e = 3; e <= 12; e++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first_at < 0) first_at = e;
        chk("ignore product", {24'd0, product}, 143);
      end
    end
    chk("ignore pulse count", pulses, 1);
    chk("ignore done edge", first_at, 4);
  endtask

  task automatic test_reset_run();
    int pulses;
    @(negedge clk);
    start = 1'b1; m = 4'd13; q = 4'd11;
    @(posedge clk); #1;
    start = 1'b0; m = '0; q = '0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort product", {24'd0, product}, 0);
    chk("abort done", {31'd0, done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("abort no activity", pulses, 0);
    run_op(4'd2, 4'd3, 8'd6, EE ? 2 : 4, "2x3 after reset");
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    start = 1'b1; m = 4'd15; q = 4'd15;
    @(posedge clk); #1;
    m = 4'd0; q = 4'd9;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b first latency", n, 4);
    chk("b2b first product", {24'd0, product}, 225);
    @(posedge clk); #1;
    chk("b2b restart busy", {31'd0, busy}, 1);
    chk("b2b restart done", {31'd0, done}, 0);
    chk("b2b product kept", {24'd0, product}, 225);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b second latency", n, 4);
    chk("b2b second product", {24'd0, product}, 0);
    @(posedge clk); #1;
    chk("b2b idle after", {30'd0, busy, done}, 0);
  endtask

  always @(negedge clk) begin
    if (busy && done) begin
      n_total++;
      $display("FAIL busy/done overlap: busy=%0b done=%0b required not both", busy, done);
    end
  end

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
